// File: rtl/uart_link.sv
// uart_link: 8N1 UART with independent RX and TX paths.
// RX: 2-flop synchronizer, mid-bit sampling, and a frame-error pulse
//     with a wait-for-idle state after a bad stop bit.
// TX: shifter plus a one-entry holding register, so a queued byte goes
//     out back-to-back with the current frame.
module uart_link #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic       txd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_frame_err,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_overrun
);

    localparam int CW = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;

    rx_state_t     rx_state, rx_next;
    logic          rx_s1, rx_s2, rx_prev;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_fall, rx_half_tick, rx_bit_tick;

    assign rx_fall      = rx_prev & ~rx_s2;
    assign rx_half_tick = (rx_cnt == HALF_LAST);
    assign rx_bit_tick  = (rx_cnt == BIT_LAST);

    // Synchronize rxd; rx_prev holds the previous synchronized level for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    // RX next-state logic
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_half_tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_bit_tick && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (rx_bit_tick) rx_next = rx_s2 ? RX_IDLE : RX_WAIT;
            RX_WAIT:  if (rx_s2) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX baud counter, shift register and registered output pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt       <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (rx_state)
                RX_START: rx_cnt <= rx_half_tick ? '0 : rx_cnt + CW'(1);
                RX_DATA: begin
                    if (rx_bit_tick) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit_tick) begin
                        rx_cnt <= '0;
                        if (rx_s2) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CW'(1);
                    end
                end
                default: begin
                    // idle / wait: counters parked at zero for the next frame
                    rx_cnt <= '0;
                    rx_bit <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t     tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic [7:0]    hold;
    logic          hold_full, hold_full_next;
    logic          tx_tick, stop_end;
    logic          load_direct, load_hold, store_hold;

    assign tx_tick  = (tx_cnt == BIT_LAST);
    assign stop_end = (tx_state == TX_STOP) && tx_tick;

    // A request is taken straight into the shifter when the shifter is free
    // this cycle (idle, or finishing a stop bit with nothing queued);
    // otherwise it goes to the holding register, or is dropped if that is full.
    assign load_direct = tx_valid && !hold_full && ((tx_state == TX_IDLE) || stop_end);
    assign load_hold   = stop_end && hold_full;
    assign store_hold  = tx_valid && !hold_full && !load_direct && (tx_state != TX_IDLE);

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    // TX next-state logic and next holding-register flag
    always_comb begin
        tx_next        = tx_state;
        hold_full_next = hold_full;
        if (store_hold)     hold_full_next = 1'b1;
        else if (load_hold) hold_full_next = 1'b0;
        case (tx_state)
            TX_IDLE:  if (load_direct) tx_next = TX_START;
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_tick) tx_next = (load_hold || load_direct) ? TX_START : TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX baud counter, shifter, holding register and registered line/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            tx_overrun <= tx_valid && hold_full;
            hold_full  <= hold_full_next;
            tx_busy    <= (tx_next != TX_IDLE) || hold_full_next;
            if (store_hold) hold <= tx_data;
            tx_cnt <= (tx_state == TX_IDLE || tx_tick) ? '0 : tx_cnt + CW'(1);
            case (tx_state)
                TX_IDLE: begin
                    if (load_direct) begin
                        tx_shift <= tx_data;
                        txd      <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_tick) begin
                        txd      <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= '0;
                    end
                end
                TX_DATA: begin
                    if (tx_tick) begin
                        tx_bit <= tx_bit + 3'd1;
                        if (tx_bit == 3'd7) begin
                            txd <= 1'b1;
                        end else begin
                            txd      <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end
                end
                TX_STOP: begin
                    if (tx_tick) begin
                        if (load_hold) begin
                            tx_shift <= hold;
                            txd      <= 1'b0;
                        end else if (load_direct) begin
                            tx_shift <= tx_data;
                            txd      <= 1'b0;
                        end else begin
                            txd <= 1'b1;
                        end
                    end
                end
                default: txd <= 1'b1;
            endcase
        end
    end

endmodule
